// File: rtl/mem_bus_responder_pkg.sv
// Shared constants and types for the memory-bus responder: IO window decode,
// offsets and the registered previous-access record.
package mem_bus_responder_pkg;

    localparam int unsigned BUS_ADDR_W         = 32;
    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned MEM_RAM_ADDR_WIDTH = 17;
    localparam int unsigned TX_DEPTH_BIT_DEF   = 3;
    localparam int unsigned RX_DEPTH_BIT_DEF   = 3;
    localparam int unsigned FULL_MARGIN_DEF    = 2;

    localparam logic [1:0] IO_SPACE_HI = 2'b11;
    localparam logic [2:0] IO_UART_OFF = 3'd0;
    localparam logic [2:0] IO_HALT_OFF = 3'd4;

    typedef struct packed {
        logic [2:0] off;
        logic       rd;
        logic       wr;
    } io_access_t;

    function automatic logic is_io(input logic [BUS_ADDR_W-1:0] a);
        return a[17:16] == IO_SPACE_HI;
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// CPU-side byte-wide memory bus: address/strobe/write data out of the CPU,
// registered read data and the TX back-pressure flag back to it.
interface mem_bus_responder_if;
    import mem_bus_responder_pkg::*;

    logic [BUS_ADDR_W-1:0] mem_a;
    logic                  mem_wr;
    logic [BYTE_W-1:0]     mem_dout;
    logic [BYTE_W-1:0]     mem_din;
    logic                  io_buffer_full;

    modport master (output mem_a, mem_wr, mem_dout, input mem_din, io_buffer_full);
    modport slave  (input mem_a, mem_wr, mem_dout, output mem_din, io_buffer_full);

endinterface

// File: rtl/mem_bus_responder_byte_fifo.sv
// Byte FIFO with power-of-two depth; a pop frees its slot for a push in the
// same cycle, so a full FIFO accepts a push when it is also being popped.
module mem_bus_responder_byte_fifo
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned DEPTH_BIT = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                push,
    input  logic [BYTE_W-1:0]   push_data,
    input  logic                pop,
    output logic [BYTE_W-1:0]   head,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_BIT:0]  count,
    output logic [DEPTH_BIT:0]  count_next
);

    localparam int unsigned DEPTH = 1 << DEPTH_BIT;
    localparam int unsigned CNT_W = DEPTH_BIT + 1;

    logic [BYTE_W-1:0]    store [DEPTH];
    logic [DEPTH_BIT-1:0] wr_ptr;
    logic [DEPTH_BIT-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + CNT_W'(1);
        else if (do_pop && !do_push)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_BIT'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_BIT'(1);
            count <= count_next;
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk_in) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: byte RAM with one-cycle registered reads plus an IO
// window holding the UART TX/RX FIFOs and a sticky halt register.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = MEM_RAM_ADDR_WIDTH,
    parameter int unsigned TX_DEPTH_BIT = TX_DEPTH_BIT_DEF,
    parameter int unsigned RX_DEPTH_BIT = RX_DEPTH_BIT_DEF,
    parameter int unsigned FULL_MARGIN  = FULL_MARGIN_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    mem_bus_responder_if.slave    bus,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [BYTE_W-1:0]     rx_data,
    input  logic                  rx_valid,
    output logic                  rx_full,
    output logic                  halt
);

    localparam int unsigned RAM_BYTES = 1 << ADDR_WIDTH;
    localparam int unsigned TX_DEPTH  = 1 << TX_DEPTH_BIT;
    localparam int unsigned TX_CNT_W  = TX_DEPTH_BIT + 1;

    logic [BYTE_W-1:0]     ram [RAM_BYTES];
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  io;
    io_access_t            cur;
    io_access_t            prev;
    logic                  rd_new;
    logic                  wr_new;
    logic                  tx_overflow;

    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic [TX_DEPTH_BIT:0] tx_count, tx_count_next;
    logic                  rx_push, rx_pop, rx_empty;
    logic [BYTE_W-1:0]     rx_head;
    logic [RX_DEPTH_BIT:0] rx_count, rx_count_next;

    assign io      = is_io(bus.mem_a);
    assign ram_idx = bus.mem_a[ADDR_WIDTH-1:0];

    // Held addresses/strobes fire side effects only on their first cycle.
    always_comb begin
        cur     = '0;
        cur.off = bus.mem_a[2:0];
        cur.rd  = io && !bus.mem_wr;
        cur.wr  = io && bus.mem_wr;
    end

    assign rd_new = cur.rd && !(prev.rd && (prev.off == cur.off));
    assign wr_new = cur.wr && !(prev.wr && (prev.off == cur.off));

    assign tx_push  = wr_new && (cur.off == IO_UART_OFF);
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_valid = !tx_empty;
    assign rx_push  = rx_valid && !rx_full;
    assign rx_pop   = rd_new && (cur.off == IO_UART_OFF) && !rx_empty;

    mem_bus_responder_byte_fifo #(.DEPTH_BIT(TX_DEPTH_BIT)) u_tx_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .push       (tx_push),
        .push_data  (bus.mem_dout),
        .pop        (tx_pop),
        .head       (tx_data),
        .full       (tx_full),
        .empty      (tx_empty),
        .count      (tx_count),
        .count_next (tx_count_next)
    );

    mem_bus_responder_byte_fifo #(.DEPTH_BIT(RX_DEPTH_BIT)) u_rx_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .push       (rx_push),
        .push_data  (rx_data),
        .pop        (rx_pop),
        .head       (rx_head),
        .full       (rx_full),
        .empty      (rx_empty),
        .count      (rx_count),
        .count_next (rx_count_next)
    );

    always_ff @(posedge clk_in) begin
        if (!io && bus.mem_wr) ram[ram_idx] <= bus.mem_dout;
    end

    // Read data, halt, overflow and back-pressure registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.mem_din        <= '0;
            bus.io_buffer_full <= 1'b0;
            halt               <= 1'b0;
            tx_overflow        <= 1'b0;
            prev               <= '0;
        end else begin
            prev               <= cur;
            bus.io_buffer_full <= (TX_CNT_W'(TX_DEPTH) - tx_count_next) <= TX_CNT_W'(FULL_MARGIN);
            if (tx_push && tx_full && !tx_pop)
                tx_overflow <= 1'b1;
            if (wr_new && (cur.off == IO_HALT_OFF))
                halt <= 1'b1;
            if (!bus.mem_wr) begin
                if (!io)
                    bus.mem_din <= ram[ram_idx];
                else if (cur.off != IO_UART_OFF)
                    bus.mem_din <= '0;
                else if (rd_new)
                    bus.mem_din <= rx_empty ? '0 : rx_head;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.mem_a, tx_count, rx_count, rx_count_next, tx_overflow};

endmodule
